// File: rtl/atm_pkg.sv
// Shared types, denomination table and helpers for the ATM deposit controller.
package atm_pkg;

    localparam int unsigned DENOM_AMT_W = 8;
    localparam int unsigned DENOM_N     = 6;

    typedef logic [DENOM_AMT_W-1:0] DENOM_T;

    localparam DENOM_T DENOM [DENOM_N] = '{
        8'd1, 8'd5, 8'd10, 8'd20, 8'd50, 8'd100
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        REFUND = 2'd2
    } state_e;

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    // Table lookup; indices past the table decode to zero.
    function automatic DENOM_T denom_lookup(input int unsigned idx);
        DENOM_T r;
        r = '0;
        for (int unsigned j = 0; j < DENOM_N; j++) begin
            if (idx == j) r = DENOM[j];
        end
        return r;
    endfunction

endpackage

// File: rtl/atm_denom_decode.sv
// Combinational decode of one-hot denomination switches into a note value.
module atm_denom_decode
    import atm_pkg::*;
#(
    parameter int unsigned NUM_DENOM = 6,
    parameter int unsigned AMT_W     = 8
) (
    input  logic [NUM_DENOM-1:0] sw,
    output logic [AMT_W-1:0]     value,
    output logic                 onehot_ok,
    output logic                 illegal
);

    int unsigned idx;
    logic        in_table;

    always_comb begin
        idx = 0;
        for (int unsigned k = 0; k < NUM_DENOM; k++) begin
            if (sw[k]) idx = k;
        end
    end

    always_comb begin
        onehot_ok = is_onehot(32'(sw));
        in_table  = (idx < DENOM_N);
        value     = (onehot_ok && in_table) ? AMT_W'(denom_lookup(idx)) : '0;
        // Multi-hot and out-of-table switches are both errors.
        illegal   = (sw != '0) && !(onehot_ok && in_table);
    end

endmodule

// File: rtl/atm_deposit_ctrl.sv
// Clocked deposit accumulator with overflow reject and buy/cancel settlement FSM.
module atm_deposit_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned NUM_DENOM = 6,
    parameter int unsigned AMT_W     = 8,
    parameter int unsigned TOTAL_W   = 12,
    parameter int unsigned MAX_TOTAL = 999
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_DENOM-1:0] sw,
    input  logic [TOTAL_W-1:0]   price,
    input  logic                 buy,
    input  logic                 cancel,
    output logic [AMT_W-1:0]     amount,
    output logic [TOTAL_W-1:0]   total,
    output logic                 led0,
    output logic                 reject,
    output logic                 nsf,
    output logic                 vend,
    output logic [TOTAL_W-1:0]   change,
    output logic                 change_valid,
    output logic                 busy
);

    localparam int unsigned SUM_W = TOTAL_W + 1;

    state_e               state_q, state_d;
    logic [NUM_DENOM-1:0] sw_q;
    logic [AMT_W-1:0]     amount_q, amount_d;
    logic [TOTAL_W-1:0]   total_q, total_d;
    logic [TOTAL_W-1:0]   change_q, change_d;
    logic                 led0_q, reject_q, reject_d, nsf_q, nsf_d;
    logic                 vend_q, vend_d, cv_q, cv_d, busy_q;

    logic [AMT_W-1:0]     note_val;
    logic                 onehot_ok, illegal;
    logic                 insert_c;
    logic [SUM_W-1:0]     sum_c;

    atm_denom_decode #(
        .NUM_DENOM (NUM_DENOM),
        .AMT_W     (AMT_W)
    ) u_decode (
        .sw        (sw),
        .value     (note_val),
        .onehot_ok (onehot_ok),
        .illegal   (illegal)
    );

    // A note is armed only after the switches have returned to all-zero.
    assign insert_c = onehot_ok && !illegal && (sw_q == '0);
    assign sum_c    = SUM_W'(total_q) + SUM_W'(note_val);

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        amount_d = amount_q;
        change_d = '0;
        cv_d     = 1'b0;
        vend_d   = 1'b0;
        nsf_d    = 1'b0;
        reject_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cancel) begin
                    state_d  = REFUND;
                    change_d = total_q;
                    cv_d     = 1'b1;
                    total_d  = '0;
                    amount_d = '0;
                    reject_d = insert_c;
                end else if (buy) begin
                    if ((price != '0) && (total_q >= price)) begin
                        state_d  = VEND;
                        vend_d   = 1'b1;
                        change_d = total_q - price;
                        cv_d     = 1'b1;
                        total_d  = '0;
                        amount_d = '0;
                    end else begin
                        nsf_d = 1'b1;
                    end
                    reject_d = insert_c;
                end else if (insert_c) begin
                    if (sum_c > SUM_W'(MAX_TOTAL)) begin
                        reject_d = 1'b1;
                    end else begin
                        total_d  = TOTAL_W'(sum_c);
                        amount_d = note_val;
                    end
                end
            end
            VEND, REFUND: begin
                state_d  = IDLE;
                reject_d = insert_c;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sw_q     <= '0;
            amount_q <= '0;
            total_q  <= '0;
            change_q <= '0;
            led0_q   <= 1'b0;
            reject_q <= 1'b0;
            nsf_q    <= 1'b0;
            vend_q   <= 1'b0;
            cv_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sw_q     <= sw;
            amount_q <= amount_d;
            total_q  <= total_d;
            change_q <= change_d;
            led0_q   <= illegal;
            reject_q <= reject_d;
            nsf_q    <= nsf_d;
            vend_q   <= vend_d;
            cv_q     <= cv_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign amount       = amount_q;
    assign total        = total_q;
    assign led0         = led0_q;
    assign reject       = reject_q;
    assign nsf          = nsf_q;
    assign vend         = vend_q;
    assign change       = change_q;
    assign change_valid = cv_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_atm_deposit_ctrl.sv
// Directed self-checking bench for atm_deposit_ctrl.
module tb_atm_deposit_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  sw = '0;
    logic [11:0] price = '0;
    logic        buy = 1'b0;
    logic        cancel = 1'b0;
    logic [7:0]  amount;
    logic [11:0] total;
    logic        led0, reject, nsf, vend, change_valid, busy;
    logic [11:0] change;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    atm_deposit_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sw           (sw),
        .price        (price),
        .buy          (buy),
        .cancel       (cancel),
        .amount       (amount),
        .total        (total),
        .led0         (led0),
        .reject       (reject),
        .nsf          (nsf),
        .vend         (vend),
        .change       (change),
        .change_valid (change_valid),
        .busy         (busy)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic insert(input logic [5:0] s);
        sw = s;
        step();
        sw = '0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (total !== 12'd0 || amount !== 8'd0 || change !== 12'd0) begin
            failures++;
            $display("FAIL reset_values total=%0d amount=%0d change=%0d exp 0/0/0", total, amount, change);
        end
        checks++;
        if ({led0, reject, nsf, vend, change_valid, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {led0, reject, nsf, vend, change_valid, busy});
        end
    endtask

    task automatic test_hold();
        sw = 6'b000100;
        step();
        checks++;
        if (total !== 12'd10 || amount !== 8'd10) begin
            failures++;
            $display("FAIL hold_first total=%0d amount=%0d exp 10/10", total, amount);
        end
        step();
        step();
        sw = '0;
        step();
        checks++;
        if (total !== 12'd10) begin
            failures++;
            $display("FAIL hold_once total=%0d exp=10", total);
        end
        checks++;
        if (led0 !== 1'b0) begin
            failures++;
            $display("FAIL hold_led0 got=%b exp=0", led0);
        end
    endtask

    task automatic test_multihot();
        sw = 6'b000011;
        step();
        checks++;
        if (led0 !== 1'b1 || total !== 12'd10) begin
            failures++;
            $display("FAIL multihot led0=%b total=%0d exp 1/10", led0, total);
        end
        sw = '0;
        step();
        checks++;
        if (led0 !== 1'b0) begin
            failures++;
            $display("FAIL multihot_clear led0=%b exp=0", led0);
        end
    endtask

    task automatic do_cancel(input logic [11:0] exp_change, input string tag);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++;
        if (change_valid !== 1'b1 || change !== exp_change || total !== 12'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s cv=%b change=%0d total=%0d busy=%b exp 1/%0d/0/1",
                     tag, change_valid, change, total, busy, exp_change);
        end
        step();
        checks++;
        if (change_valid !== 1'b0 || change !== 12'd0 || busy !== 1'b0 || amount !== 8'd0) begin
            failures++;
            $display("FAIL %s_after cv=%b change=%0d busy=%b amount=%0d exp 0/0/0/0",
                     tag, change_valid, change, busy, amount);
        end
    endtask

    task automatic test_overflow();
        do_cancel(12'd10, "refund10");
        for (int i = 0; i < 9; i++) insert(6'b100000);
        checks++;
        if (total !== 12'd900 || amount !== 8'd100) begin
            failures++;
            $display("FAIL ovf_fill total=%0d amount=%0d exp 900/100", total, amount);
        end
        sw = 6'b100000;
        step();
        checks++;
        if (reject !== 1'b1 || total !== 12'd900) begin
            failures++;
            $display("FAIL ovf_reject reject=%b total=%0d exp 1/900", reject, total);
        end
        sw = '0;
        step();
        checks++;
        if (reject !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pulse reject=%b exp=0", reject);
        end
        insert(6'b010000);
        checks++;
        if (total !== 12'd950 || amount !== 8'd50) begin
            failures++;
            $display("FAIL ovf_fit total=%0d amount=%0d exp 950/50", total, amount);
        end
        do_cancel(12'd950, "refund950");
    endtask

    task automatic test_buy();
        insert(6'b001000);
        insert(6'b000100);
        insert(6'b000010);
        price = 12'd20;
        buy = 1'b1;
        step();
        buy = 1'b0;
        checks++;
        if (vend !== 1'b1 || change_valid !== 1'b1 || change !== 12'd15 || busy !== 1'b1 || total !== 12'd0) begin
            failures++;
            $display("FAIL buy_vend vend=%b cv=%b change=%0d busy=%b total=%0d exp 1/1/15/1/0",
                     vend, change_valid, change, busy, total);
        end
        step();
        checks++;
        if (vend !== 1'b0 || change_valid !== 1'b0 || change !== 12'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL buy_after vend=%b cv=%b change=%0d busy=%b exp 0/0/0/0", vend, change_valid, change, busy);
        end
        insert(6'b001000);
        insert(6'b000100);
        insert(6'b000010);
        price = 12'd40;
        buy = 1'b1;
        step();
        buy = 1'b0;
        checks++;
        if (nsf !== 1'b1 || vend !== 1'b0 || total !== 12'd35 || busy !== 1'b0) begin
            failures++;
            $display("FAIL buy_nsf nsf=%b vend=%b total=%0d busy=%b exp 1/0/35/0", nsf, vend, total, busy);
        end
        step();
        checks++;
        if (nsf !== 1'b0) begin
            failures++;
            $display("FAIL nsf_pulse nsf=%b exp=0", nsf);
        end
        price = 12'd0;
        buy = 1'b1;
        step();
        buy = 1'b0;
        checks++;
        if (nsf !== 1'b1 || vend !== 1'b0 || total !== 12'd35) begin
            failures++;
            $display("FAIL price_zero nsf=%b vend=%b total=%0d exp 1/0/35", nsf, vend, total);
        end
        step();
        do_cancel(12'd35, "refund35");
        do_cancel(12'd0, "refund_zero");
    endtask

    task automatic test_priority();
        insert(6'b001000);
        insert(6'b000010);
        price = 12'd5;
        sw = 6'b000010;
        buy = 1'b1;
        cancel = 1'b1;
        step();
        buy = 1'b0;
        cancel = 1'b0;
        sw = '0;
        checks++;
        if (change_valid !== 1'b1 || change !== 12'd25 || reject !== 1'b1 || vend !== 1'b0 || total !== 12'd0) begin
            failures++;
            $display("FAIL prio cv=%b change=%0d reject=%b vend=%b total=%0d exp 1/25/1/0/0",
                     change_valid, change, reject, vend, total);
        end
        step();
        checks++;
        if (reject !== 1'b0 || busy !== 1'b0 || total !== 12'd0) begin
            failures++;
            $display("FAIL prio_after reject=%b busy=%b total=%0d exp 0/0/0", reject, busy, total);
        end
    endtask

    task automatic test_reset_in_vend();
        insert(6'b000100);
        price = 12'd10;
        buy = 1'b1;
        step();
        buy = 1'b0;
        checks++;
        if (vend !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre vend=%b busy=%b exp 1/1", vend, busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({led0, reject, nsf, vend, change_valid, busy} !== 6'b0 || total !== 12'd0 || change !== 12'd0 || amount !== 8'd0) begin
            failures++;
            $display("FAIL rst_vend flags=%b total=%0d change=%0d amount=%0d exp 0",
                     {led0, reject, nsf, vend, change_valid, busy}, total, change, amount);
        end
        insert(6'b000010);
        checks++;
        if (total !== 12'd5 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_idle total=%0d busy=%b exp 5/0", total, busy);
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_multihot();
        test_overflow();
        test_buy();
        test_priority();
        test_reset_in_vend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
